// File: rtl/data_memory_bank_pkg.sv
// data_memory_bank_pkg: shared defaults and FSM encodings for the data memory bank
package data_memory_bank_pkg;
  localparam int DMEM_WORD_SIZE = 32;
  localparam int DMEM_ADDRW = 8;
  localparam int DMEM_DEPTH = 256;
  localparam int DMEM_NRD = 2;
  localparam int DMEM_RD_LAT = 1;
  localparam int DMEM_RDW_MODE = 0;
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN = 1'b1;
endpackage

// File: rtl/data_memory_bank_read_port.sv
// dmem_read_port: one read port with write bypass, range zeroing and latency pipeline
module dmem_read_port
  import data_memory_bank_pkg::*;
#(
  parameter int WORD_SIZE = DMEM_WORD_SIZE,
  parameter int DEPTH = DMEM_DEPTH,
  parameter int ADDRW = DMEM_ADDRW,
  parameter int RD_LAT = DMEM_RD_LAT,
  parameter int RDW_MODE = DMEM_RDW_MODE
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  input  logic                   ren,
  input  logic [ADDRW-1:0]       raddr,
  input  logic [WORD_SIZE-1:0]   mem_word,
  input  logic                   wr_ok,
  input  logic [ADDRW-1:0]       waddr,
  input  logic [WORD_SIZE/8-1:0] wbe,
  input  logic [WORD_SIZE-1:0]   wdata,
  output logic [WORD_SIZE-1:0]   rdata,
  output logic                   rvalid
);
  localparam logic [ADDRW:0] DEPTH_W = (ADDRW+1)'(DEPTH);
  logic in_range, hit, v1;
  logic [WORD_SIZE-1:0] merged, rd_next, d1;
  assign in_range = {1'b0, raddr} < DEPTH_W;
  assign hit = wr_ok && waddr == raddr;
  always_comb begin
    merged = mem_word;
    for (int k = 0; k < WORD_SIZE/8; k++)
      merged[8*k +: 8] = wbe[k] ? wdata[8*k +: 8] : mem_word[8*k +: 8];
  end
  assign rd_next = !in_range ? '0 : (hit && RDW_MODE != 0) ? merged : mem_word;
  always_ff @(posedge clk)
    if (rst) begin
      v1 <= 1'b0;
      d1 <= '0;
    end else begin
      v1 <= run && ren;
      if (run && ren) d1 <= rd_next;
    end
  generate
    if (RD_LAT == 2) begin : g_lat2
      logic v2;
      logic [WORD_SIZE-1:0] d2;
      always_ff @(posedge clk)
        if (rst) begin
          v2 <= 1'b0;
          d2 <= '0;
        end else begin
          v2 <= v1;
          if (v1) d2 <= d1;
        end
      assign rdata = d2;
      assign rvalid = v2;
    end else begin : g_lat1
      assign rdata = d1;
      assign rvalid = v1;
    end
  endgenerate
endmodule

// File: rtl/data_memory_bank.sv
// data_memory_bank: byte-enabled write port, NRD read ports, zero-fill sequencer after reset
module data_memory_bank
  import data_memory_bank_pkg::*;
#(
  parameter int WORD_SIZE = DMEM_WORD_SIZE,
  parameter int DEPTH = DMEM_DEPTH,
  parameter int ADDRW = DMEM_ADDRW,
  parameter int NRD = DMEM_NRD,
  parameter int RD_LAT = DMEM_RD_LAT,
  parameter int RDW_MODE = DMEM_RDW_MODE,
  parameter int INIT_ZERO = 1
)(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wen,
  input  logic [WORD_SIZE/8-1:0]   wbe,
  input  logic [ADDRW-1:0]         waddr,
  input  logic [WORD_SIZE-1:0]     wdata,
  input  logic [NRD-1:0]           ren,
  input  logic [NRD*ADDRW-1:0]     raddr,
  output logic [NRD*WORD_SIZE-1:0] rdata,
  output logic [NRD-1:0]           rvalid,
  output logic                     ready
);
  localparam logic [ADDRW:0] DEPTH_W = (ADDRW+1)'(DEPTH);
  logic [WORD_SIZE-1:0] mem [DEPTH];
  logic [0:0] state;
  logic [ADDRW:0] cnt;
  logic wr_ok;
  assign ready = state == ST_RUN;
  assign wr_ok = ready && wen && {1'b0, waddr} < DEPTH_W;
  always_ff @(posedge clk)
    if (rst) begin
      state <= INIT_ZERO != 0 ? ST_INIT : ST_RUN;
      cnt <= '0;
    end else if (state == ST_INIT) begin
      cnt <= cnt + 1'b1;
      if (cnt == DEPTH_W - 1'b1) state <= ST_RUN;
    end
  always_ff @(posedge clk)
    if (!rst && state == ST_INIT)
      mem[cnt[ADDRW-1:0]] <= '0;
    else if (!rst && wr_ok)
      for (int k = 0; k < WORD_SIZE/8; k++)
        if (wbe[k]) mem[waddr][8*k +: 8] <= wdata[8*k +: 8];
  // out-of-range array reads are masked to zero inside each port
  genvar i;
  for (i = 0; i < NRD; i++) begin : g_rd
    dmem_read_port #(
      .WORD_SIZE(WORD_SIZE), .DEPTH(DEPTH), .ADDRW(ADDRW), .RD_LAT(RD_LAT), .RDW_MODE(RDW_MODE)
    ) u_rd (
      .clk(clk), .rst(rst), .run(ready), .ren(ren[i]),
      .raddr(raddr[i*ADDRW +: ADDRW]), .mem_word(mem[raddr[i*ADDRW +: ADDRW]]),
      .wr_ok(wr_ok), .waddr(waddr), .wbe(wbe), .wdata(wdata),
      .rdata(rdata[i*WORD_SIZE +: WORD_SIZE]), .rvalid(rvalid[i])
    );
  end
endmodule

// File: tb/tb_data_memory_bank.sv
// tb_data_memory_bank: two configurations (lat2/read-first, lat1/write-first) against a queue-based model
module tb_data_memory_bank;
  localparam int W = 32, D = 200, AW = 8, N = 2;
  logic clk = 0, rst = 1, wen = 0;
  logic [3:0] wbe = 0;
  logic [AW-1:0] waddr = 0;
  logic [W-1:0] wdata = 0;
  logic [N-1:0] ren = 0;
  logic [N*AW-1:0] raddr = 0;
  logic [N*W-1:0] rdata_a, rdata_b;
  logic [N-1:0] rvalid_a, rvalid_b;
  logic ready_a, ready_b;
  always #5 clk = ~clk;
  data_memory_bank #(.WORD_SIZE(W), .DEPTH(D), .ADDRW(AW), .NRD(N), .RD_LAT(2), .RDW_MODE(0), .INIT_ZERO(1)) dut_a (
    .clk(clk), .rst(rst), .wen(wen), .wbe(wbe), .waddr(waddr), .wdata(wdata),
    .ren(ren), .raddr(raddr), .rdata(rdata_a), .rvalid(rvalid_a), .ready(ready_a));
  data_memory_bank #(.WORD_SIZE(W), .DEPTH(D), .ADDRW(AW), .NRD(N), .RD_LAT(1), .RDW_MODE(1), .INIT_ZERO(1)) dut_b (
    .clk(clk), .rst(rst), .wen(wen), .wbe(wbe), .waddr(waddr), .wdata(wdata),
    .ren(ren), .raddr(raddr), .rdata(rdata_b), .rvalid(rvalid_b), .ready(ready_b));
  typedef struct {int due; logic [W-1:0] data;} req_t;
  req_t pend [2][N][$];
  logic [W-1:0] ref_mem [D];
  logic [W-1:0] last [2][N];
  int lat [2] = '{2, 1};
  int mode [2] = '{0, 1};
  int init_left = D, cyc = 0, checks = 0, passed = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
  endtask
  function automatic logic [W-1:0] byte_merge(input logic [W-1:0] old, input logic [W-1:0] nw, input logic [3:0] be);
    logic [W-1:0] r = old;
    for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = nw[8*k +: 8];
    return r;
  endfunction
  task automatic step;
    logic [AW-1:0] a;
    logic [W-1:0] old, val;
    logic [N*W-1:0] rd;
    logic [N-1:0] rv;
    logic ev;
    bit wr;
    cyc++;
    if (rst) begin
      init_left = D;
      for (int d = 0; d < 2; d++) for (int p = 0; p < N; p++) begin
        pend[d][p].delete();
        last[d][p] = '0;
      end
    end else if (init_left > 0) begin
      init_left--;
      if (init_left == 0) foreach (ref_mem[j]) ref_mem[j] = '0;
    end else begin
      wr = wen && waddr < D;
      for (int p = 0; p < N; p++) if (ren[p]) begin
        a = raddr[p*AW +: AW];
        old = a < D ? ref_mem[a] : '0;
        for (int d = 0; d < 2; d++) begin
          val = a >= D ? '0 : (mode[d] == 1 && wr && waddr == a) ? byte_merge(old, wdata, wbe) : old;
          pend[d][p].push_back('{cyc + lat[d] - 1, val});
        end
      end
      if (wr) ref_mem[waddr] = byte_merge(ref_mem[waddr], wdata, wbe);
    end
    @(posedge clk);
    #1;
    check("ready_a", ready_a, init_left == 0);
    check("ready_b", ready_b, init_left == 0);
    for (int d = 0; d < 2; d++) begin
      rd = d == 0 ? rdata_a : rdata_b;
      rv = d == 0 ? rvalid_a : rvalid_b;
      for (int p = 0; p < N; p++) begin
        ev = 0;
        if (pend[d][p].size() > 0) if (pend[d][p][0].due == cyc) begin
          ev = 1;
          last[d][p] = pend[d][p][0].data;
          void'(pend[d][p].pop_front());
        end
        check($sformatf("rvalid%s%0d", d == 0 ? "A" : "B", p), rv[p], ev);
        check($sformatf("rdata%s%0d", d == 0 ? "A" : "B", p), rd[p*W +: W], last[d][p]);
      end
    end
  endtask
  task automatic idle(input int n);
    wen = 0; ren = 0;
    repeat (n) step();
  endtask
  task automatic wr_word(input int a, input logic [W-1:0] v, input logic [3:0] be);
    wen = 1; waddr = AW'(a); wdata = v; wbe = be; ren = 0;
    step();
    wen = 0;
  endtask
  task automatic read_all;
    wen = 0; ren = 2'b11;
    for (int a = 0; a < D; a++) begin
      raddr = {AW'(D - 1 - a), AW'(a)};
      step();
    end
    idle(3);
  endtask
  task automatic fill(input int n);
    for (int c = 0; c < n; c++) begin
      wen = 1; waddr = AW'($urandom_range(0, 255)); wdata = $urandom; wbe = 4'hF;
      ren = 2'b11; raddr = N*AW'($urandom);
      step();
    end
    wen = 0; ren = 0;
  endtask
  initial begin
    rst = 1; step();
    rst = 0; fill(8);
    rst = 1; step();
    rst = 0; fill(D);
    idle(2);
    read_all();
    wr_word(5, 32'hAABBCCDD, 4'hF);
    wr_word(5, 32'h11223344, 4'h5);
    ren = 2'b01; raddr = {AW'(0), AW'(5)}; step();
    idle(3);
    for (int a = 0; a < 4; a++) wr_word(a, 32'h10 + a, 4'hF);
    for (int a = 0; a < 4; a++) begin
      ren = 2'b01; raddr = {AW'(0), AW'(a)}; step();
    end
    idle(3);
    wr_word(7, 32'h0, 4'hF);
    wen = 1; waddr = 7; wdata = 32'hFFFFFFFF; wbe = 4'h3; ren = 2'b11; raddr = {AW'(7), AW'(7)};
    step();
    idle(3);
    wr_word(9, 32'h99, 4'hF);
    ren = 2'b11; raddr = {AW'(250), AW'(9)}; step();
    idle(3);
    wr_word(250, 32'hDEADBEEF, 4'hF);
    ren = 2'b01; raddr = {AW'(0), AW'(3)}; step();
    ren = 0; rst = 1; step();
    rst = 0; idle(D + 2);
    read_all();
    for (int c = 0; c < 600; c++) begin
      wen = $urandom_range(0, 1);
      wbe = 4'($urandom);
      waddr = $urandom_range(0, 3) == 0 ? AW'($urandom_range(0, 255)) : AW'($urandom_range(0, 7));
      wdata = $urandom;
      ren = N'($urandom);
      for (int p = 0; p < N; p++)
        raddr[p*AW +: AW] = $urandom_range(0, 3) == 0 ? AW'($urandom_range(0, 255)) : AW'($urandom_range(0, 7));
      step();
    end
    idle(3);
    read_all();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
